mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: A  in  32  operand rs (multiplicand or dividend); same source as the ALU A operand.
REQ-004 SHALL have: B  in  32  operand rt (multiplier or divisor); same source as the ALU B operand.
REQ-005 SHALL have: op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have: start  in  1  request; sampled with A, B and op on a rising edge.
REQ-007 SHALL have: hi_we, lo_we  in  1 each  MTHI and MTLO write enables, taking data from A.
REQ-008 SHALL have: hi, lo  out  32 each  architectural HI and LO registers (MFHI and MFLO source).
REQ-009 SHALL have: busy  out  1  operation in progress.
REQ-010 SHALL have: done  out  1  one-cycle completion pulse.
REQ-011 SHALL have: div_zero  out  1  last completed divide had B==0.
REQ-012 SHALL have: one clock and asynchronous active-low reset, as stated in REQ-001 and REQ-002.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX and WRITE; IDLE->CALC on start; CALC->FIX after 32 iterations; FIX->WRITE; WRITE->IDLE.
REQ-014 SHALL accept start only in IDLE; start in any other state is ignored and leaves the operation in progress unaffected.
REQ-015 On acceptance SHALL latch A, B and op.
REQ-015a For signed ops, on acceptance SHALL also record the operand signs and convert both operands to magnitudes.
REQ-016 CALC SHALL run a 6-bit counter 0..31, performing one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle.
REQ-017 FIX SHALL apply sign correction:
- MULT: negate the 64-bit product if the operand signs differ.
- DIV: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend (truncation toward zero).
REQ-018 WRITE SHALL load the results: multiply {hi,lo}=64-bit product; divide lo=quotient, hi=remainder.
REQ-018a done SHALL be asserted for the cycle after the WRITE edge, exactly 35 rising edges after the edge that sampled start.
REQ-019 busy SHALL be 1 from the edge after the start sample through the WRITE edge, and 0 in the cycle where done=1.
REQ-019a A new start SHALL be accepted in the same cycle that done=1.
REQ-020 Divisor zero (DIV/DIVU, B==0): SHALL take full latency; lo=32'hFFFF_FFFF, hi=A; div_zero=1 with done.
REQ-020a div_zero SHALL be cleared on the next accepted start.
REQ-021 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give lo=32'h8000_0000, hi=0, with no exception.
REQ-022 hi_we/lo_we SHALL write A to hi/lo on the edge only while in IDLE; while busy they are ignored.
REQ-022a If start and hi_we/lo_we are both asserted in IDLE on the same edge, the MT write SHALL take effect and the operation SHALL also start.
REQ-022b The WRITE-state result SHALL later overwrite any value written by such a same-edge MT write.
REQ-023 hi and lo SHALL hold their values except on the WRITE edge or an accepted MT write; intermediate values SHALL never be visible on hi or lo.
REQ-024 All arithmetic SHALL be bit-exact to MIPS32 semantics for all 2^64 operand combinations, with no X or Z on any output after reset.

Reset
REQ-025 rst_n low SHALL immediately force hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE and counter=0, without waiting for a clock edge.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no partial result written.
REQ-026a The first start after rst_n rises SHALL be accepted on the first rising edge.

Verification
REQ-027 MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> after 35 edges done=1, hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-028 MULT A=-3 (32'hFFFF_FFFD), B=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-029 DIV A=-7, B=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU A=7, B=2 -> lo=3, hi=1.
REQ-030 DIVU A=32'h1234, B=0 -> lo=32'hFFFF_FFFF, hi=32'h1234, div_zero=1; DIV 32'h8000_0000 by -1 -> lo=32'h8000_0000, hi=0.
REQ-031 Start MULTU 5x5, then pulse start (DIVU 9/3) and hi_we with A=32'hDEAD at cycle 10 -> both ignored; after 35 edges from the first start, hi=0 and lo=25.
REQ-032 Start DIV, drop rst_n at cycle 20 -> all outputs 0 immediately; release, MTLO A=32'hABCD in IDLE -> lo=32'hABCD next edge, busy=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply/divide unit with architectural HI/LO registers.
// Takes one shift-add or restoring shift-subtract step per cycle; the full operation takes 35 edges from start to done.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, WRITE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] a_q, a_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        bzero_q, bzero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [31:0] quot_fix, rem_fix;
  logic [63:0] prod_fix;

  // Signed ops (op[0]==0) work on magnitudes; signs are restored in FIX.
  assign sign_a = ~op[0] & A[31];
  assign sign_b = ~op[0] & B[31];
  assign mag_a  = sign_a ? (~A + 32'd1) : A;
  assign mag_b  = sign_b ? (~B + 32'd1) : B;

  // p_q holds {partial, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, p_q[63:32]} + {1'b0, opnd_q};
  assign div_ge   = (p_q[63:31] >= {1'b0, opnd_q});
  assign div_diff = p_q[62:31] - opnd_q;

  assign quot_fix = neg_res_q ? (~p_q[31:0] + 32'd1) : p_q[31:0];
  assign rem_fix  = neg_rem_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];
  assign prod_fix = neg_res_q ? (~p_q + 64'd1) : p_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = dz_q;

    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = A;
        if (lo_we) lo_d = A;
        if (start) begin
          state_d   = CALC;
          cnt_d     = 6'd0;
          p_d       = {32'd0, mag_a};
          opnd_d    = mag_b;
          a_d       = A;
          is_div_d  = op[1];
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          bzero_d   = (B == 32'd0);
          dz_d      = 1'b0;
        end
      end
      CALC: begin
        // Counter bit 5 set means all 32 steps have been taken.
        if (cnt_q[5]) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (is_div_q) begin
            if (div_ge) p_d = {div_diff, p_q[30:0], 1'b1};
            else        p_d = {p_q[62:0], 1'b0};
          end else begin
            if (p_q[0]) p_d = {mul_sum, p_q[31:1]};
            else        p_d = {1'b0, p_q[63:1]};
          end
        end
      end
      FIX: begin
        state_d = WRITE;
        if (is_div_q) begin
          if (bzero_q) p_d = {a_q, 32'hFFFF_FFFF};
          else         p_d = {rem_fix, quot_fix};
        end else begin
          p_d = prod_fix;
        end
      end
      WRITE: begin
        state_d = IDLE;
        hi_d    = p_q[63:32];
        lo_d    = p_q[31:0];
        done_d  = 1'b1;
        dz_d    = is_div_q & bzero_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      p_q       <= 64'd0;
      opnd_q    <= 32'd0;
      a_q       <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: vector table plus model-generated operations checked through a scoreboard queue,
// followed by hand-written sequences for ignored starts, same-edge MT writes and mid-operation reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [1:0]  op;
  logic        start, hi_we, lo_we;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
  } vec_t;

  vec_t vecs[10];
  vec_t expQ[$];

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .op(op), .start(start),
    .hi_we(hi_we), .lo_we(lo_we), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] eh, input logic [31:0] el, input logic edz);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.eh = eh; v.el = el; v.edz = edz;
    return v;
  endfunction

  // Reference results straight from MIPS arithmetic definitions, using wide host integers.
  function automatic vec_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    vec_t r;
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.op = o; r.a = a; r.b = b; r.edz = 1'b0;
    p = 64'd0;
    case (o)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) begin p = {a, 32'hFFFF_FFFF}; r.edz = 1'b1; end
        else begin sq = sa / sb; sr = sa % sb; p = {sr[31:0], sq[31:0]}; end
      end
      default: begin
        if (b == 32'd0) begin p = {a, 32'hFFFF_FFFF}; r.edz = 1'b1; end
        else p = {a % b, a / b};
      end
    endcase
    r.eh = p[63:32];
    r.el = p[31:0];
    return r;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drives one start (optionally with MT writes) and returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input vec_t v, input logic hw, input logic lw, input logic push);
    @(negedge clk);
    op = v.op; A = v.a; B = v.b; start = 1'b1; hi_we = hw; lo_we = lw;
    if (push) expQ.push_back(v);
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Waits (bounded) for done, checks latency, then compares against the scoreboard head.
  task automatic checkOutput(input int already);
    int   edges;
    bit   seen;
    vec_t e;
    edges = already;
    seen  = 1'b0;
    checkBit("busy_during_op", busy, 1'b1);
    while (!seen && edges < 80) begin
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      nTests++; nFail++;
      $display("[TB] FAIL done_timeout: got no done after %0d edges expected done at 35", edges);
    end else begin
      check32("latency", 32'(edges), 32'd35);
    end
    if (expQ.size() == 0) begin
      nTests++; nFail++;
      $display("[TB] FAIL scoreboard_empty: got empty queue expected an entry");
    end else begin
      e = expQ.pop_front();
      check32($sformatf("hi op%0d %h/%h", e.op, e.a, e.b), hi, e.eh);
      check32($sformatf("lo op%0d %h/%h", e.op, e.a, e.b), lo, e.el);
      checkBit("div_zero", div_zero, e.edz);
      checkBit("busy_at_done", busy, 1'b0);
    end
  endtask

  task automatic countStrayDone(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check32(name, 32'(pulses), 32'd0);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; A = '0; B = '0; op = '0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;

    vecs[0] = mk(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    vecs[1] = mk(2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    vecs[2] = mk(2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    vecs[3] = mk(2'd3, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
    vecs[4] = mk(2'd3, 32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, 1'b1);
    vecs[5] = mk(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    vecs[6] = mk(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0);
    vecs[7] = mk(2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
    vecs[8] = mk(2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    vecs[9] = mk(2'd1, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         1'b0);

    #12;
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    checkBit("reset_busy", busy, 1'b0);
    checkBit("reset_done", done, 1'b0);
    checkBit("reset_div_zero", div_zero, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Plain MTHI in IDLE.
    @(negedge clk); A = 32'hCAFE; hi_we = 1'b1;
    @(posedge clk); #1; hi_we = 1'b0;
    check32("mthi_idle", hi, 32'hCAFE);
    check32("mthi_lo_untouched", lo, 32'd0);

    // Same-edge MT write and start: MT value first, result later overwrites.
    applyStimulus(mk(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0), 1'b1, 1'b1, 1'b1);
    check32("same_edge_mthi", hi, 32'd3);
    check32("same_edge_mtlo", lo, 32'd3);
    checkOutput(0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], 1'b0, 1'b0, 1'b1);
      checkOutput(0);
    end

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      v = model(2'(i % 4), ra, rb);
      applyStimulus(v, 1'b0, 1'b0, 1'b1);
      checkOutput(0);
    end

    // Start and MTHI arriving mid-operation must both be ignored.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(mk(2'd1, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0), 1'b0, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk); op = 2'd3; A = 32'hDEAD; B = 32'd3; start = 1'b1; hi_we = 1'b1;
    @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
    check32("busy_mthi_ignored", hi, 32'd0);
    checkOutput(10);
    countStrayDone("ignored_start_no_second_op", 40);

    // Reset in the middle of a divide aborts it and clears everything at once.
    applyStimulus(mk(2'd2, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0), 1'b0, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check32("async_reset_hi", hi, 32'd0);
    check32("async_reset_lo", lo, 32'd0);
    checkBit("async_reset_busy", busy, 1'b0);
    checkBit("async_reset_done", done, 1'b0);
    checkBit("async_reset_div_zero", div_zero, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); A = 32'hABCD; lo_we = 1'b1;
    @(posedge clk); #1; lo_we = 1'b0;
    check32("mtlo_after_reset", lo, 32'hABCD);
    checkBit("mtlo_after_reset_busy", busy, 1'b0);
    countStrayDone("aborted_op_no_done", 40);

    // First start right after reset release is taken on the first edge.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    v = model(2'd0, 32'hFFFF_FF00, 32'd300);
    op = v.op; A = v.a; B = v.b; start = 1'b1;
    expQ.push_back(v);
    @(posedge clk); #1; start = 1'b0;
    checkOutput(0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
